// File: rtl/noc_local_ni.sv
`default_nettype none
// ============================================================================
// Module      : noc_local_ni
// Description : Local network interface between a core and a 2D-mesh router.
//               TX: 4-entry flit FIFO feeding a valid/return injection port.
//               RX: single-entry payload buffer with return-based flow control
//               and misroute detection.
// Options     : NI_TIMEOUT_EN - when defined, an unanswered injection is
//               dropped after 15 cycles in SEND and timeout_err pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module noc_local_ni (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] X_address,
  input  logic [1:0] Y_address,
  input  logic       tx_wr,
  input  logic [1:0] tx_dest_x,
  input  logic [1:0] tx_dest_y,
  input  logic [3:0] tx_payload,
  output logic       tx_full,
  output logic [7:0] Data_out_L,
  output logic       val_out_L,
  input  logic       ret_in_L,
  input  logic [7:0] Data_in_L,
  input  logic       val_in_L,
  output logic       ret_out_L,
  output logic [3:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_rd,
  output logic       rx_misroute,
  output logic       timeout_err
);

  localparam int unsigned DEPTH = 4;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } tx_state_t;

  // TX path state
  logic [7:0] mem_q    [DEPTH];
  logic [7:0] mem_d    [DEPTH];
  logic [1:0] wr_ptr_q, wr_ptr_d;
  logic [1:0] rd_ptr_q, rd_ptr_d;
  logic [2:0] count_q,  count_d;
  tx_state_t  state_q,  state_d;
  logic [7:0] data_out_q, data_out_d;
  logic       val_out_q,  val_out_d;
  logic       w_push;
  logic       w_pop;

`ifdef NI_TIMEOUT_EN
  // Last counter value before the 15th unanswered SEND cycle
  localparam logic [3:0] C_TMO_LAST = 4'd14;
  logic [3:0] tmo_cnt_q, tmo_cnt_d;
  logic       timeout_q, timeout_d;
`endif

  // RX path state
  logic [3:0] rx_data_q,  rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       ret_out_q,  ret_out_d;
  logic       misroute_q, misroute_d;
  logic       w_capture;

  assign tx_full = (count_q == 3'd4);

  // TX: FIFO push/pop and the IDLE/SEND injection handshake
  always_comb begin
    w_push     = tx_wr && !tx_full;
    w_pop      = 1'b0;
    state_d    = state_q;
    data_out_d = data_out_q;
    val_out_d  = val_out_q;
`ifdef NI_TIMEOUT_EN
    tmo_cnt_d  = tmo_cnt_q;
    timeout_d  = 1'b0;
`endif
    if (state_q == IDLE) begin
      // A flit is only presented after a cycle in IDLE, giving the gap between flits
      if (count_q != 3'd0) begin
        state_d    = SEND;
        data_out_d = mem_q[rd_ptr_q];
        val_out_d  = 1'b1;
`ifdef NI_TIMEOUT_EN
        tmo_cnt_d  = 4'd0;
`endif
      end
    end else begin
      if (ret_in_L) begin
        w_pop     = 1'b1;
        val_out_d = 1'b0;
        state_d   = IDLE;
      end
`ifdef NI_TIMEOUT_EN
      else if (tmo_cnt_q == C_TMO_LAST) begin
        // Router never returned the flit: discard it and report
        w_pop     = 1'b1;
        val_out_d = 1'b0;
        timeout_d = 1'b1;
        state_d   = IDLE;
      end else begin
        tmo_cnt_d = tmo_cnt_q + 4'd1;
      end
`endif
    end

    mem_d = mem_q;
    if (w_push) begin
      mem_d[wr_ptr_q] = {tx_dest_x, tx_dest_y, tx_payload};
    end
    wr_ptr_d = w_push ? wr_ptr_q + 2'd1 : wr_ptr_q;
    rd_ptr_d = w_pop  ? rd_ptr_q + 2'd1 : rd_ptr_q;
    count_d  = count_q + {2'b00, w_push} - {2'b00, w_pop};
  end

  // RX: capture one flit when the buffer is free (or being drained), then return it
  always_comb begin
    w_capture  = val_in_L && !ret_out_q && (!rx_valid_q || rx_rd);
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    ret_out_d  = 1'b0;
    misroute_d = 1'b0;
    if (w_capture) begin
      rx_data_d  = Data_in_L[3:0];
      rx_valid_d = 1'b1;
      ret_out_d  = 1'b1;
      misroute_d = (Data_in_L[7:6] != X_address) || (Data_in_L[5:4] != Y_address);
    end else if (rx_rd && rx_valid_q) begin
      rx_valid_d = 1'b0;
    end
  end

  // All state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 8'h00;
      end
      wr_ptr_q   <= 2'd0;
      rd_ptr_q   <= 2'd0;
      count_q    <= 3'd0;
      state_q    <= IDLE;
      data_out_q <= 8'h00;
      val_out_q  <= 1'b0;
`ifdef NI_TIMEOUT_EN
      tmo_cnt_q  <= 4'd0;
      timeout_q  <= 1'b0;
`endif
      rx_data_q  <= 4'h0;
      rx_valid_q <= 1'b0;
      ret_out_q  <= 1'b0;
      misroute_q <= 1'b0;
    end else begin
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      state_q    <= state_d;
      data_out_q <= data_out_d;
      val_out_q  <= val_out_d;
`ifdef NI_TIMEOUT_EN
      tmo_cnt_q  <= tmo_cnt_d;
      timeout_q  <= timeout_d;
`endif
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      ret_out_q  <= ret_out_d;
      misroute_q <= misroute_d;
    end
  end

  assign Data_out_L  = data_out_q;
  assign val_out_L   = val_out_q;
  assign ret_out_L   = ret_out_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign rx_misroute = misroute_q;
`ifdef NI_TIMEOUT_EN
  assign timeout_err = timeout_q;
`else
  assign timeout_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_noc_local_ni.sv
`default_nettype none
// ============================================================================
// Module      : tb_noc_local_ni
// Description : Self-checking bench for noc_local_ni: directed scenarios plus
//               a randomized run against a queue-based transaction model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_noc_local_ni;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] X_address, Y_address, tx_dest_x, tx_dest_y;
  logic       tx_wr;
  logic [3:0] tx_payload;
  logic       tx_full;
  logic [7:0] Data_out_L;
  logic       val_out_L, ret_in_L;
  logic [7:0] Data_in_L;
  logic       val_in_L, ret_out_L;
  logic [3:0] rx_data;
  logic       rx_valid, rx_rd, rx_misroute, timeout_err;

  int total = 0;
  int bad   = 0;

  // Reference model state for the randomized run
  logic [7:0] mq[$];
  logic [7:0] m_data;
  logic       m_val, m_to;
  int         m_wait;
  logic [3:0] m_rxd;
  logic       m_rxv, m_ret, m_mis;

  always #5 clk = ~clk;

  noc_local_ni dut (
    .clk         (clk),
    .rst         (rst),
    .X_address   (X_address),
    .Y_address   (Y_address),
    .tx_wr       (tx_wr),
    .tx_dest_x   (tx_dest_x),
    .tx_dest_y   (tx_dest_y),
    .tx_payload  (tx_payload),
    .tx_full     (tx_full),
    .Data_out_L  (Data_out_L),
    .val_out_L   (val_out_L),
    .ret_in_L    (ret_in_L),
    .Data_in_L   (Data_in_L),
    .val_in_L    (val_in_L),
    .ret_out_L   (ret_out_L),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_rd       (rx_rd),
    .rx_misroute (rx_misroute),
    .timeout_err (timeout_err)
  );

  task automatic idle_inputs();
    tx_wr = 1'b0; ret_in_L = 1'b0; val_in_L = 1'b0; rx_rd = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    X_address = 2'd0; Y_address = 2'd0;
    tx_dest_x = 2'd0; tx_dest_y = 2'd0; tx_payload = 4'd0; Data_in_L = 8'h00;
    repeat (2) @(negedge clk);
    total++;
    if ({Data_out_L, val_out_L, tx_full, timeout_err} !== 11'd0) begin
      bad++; $display("FAIL reset_tx: got data=%h val=%b full=%b to=%b want all 0",
                      Data_out_L, val_out_L, tx_full, timeout_err);
    end
    total++;
    if ({rx_data, rx_valid, ret_out_L, rx_misroute} !== 7'd0) begin
      bad++; $display("FAIL reset_rx: got data=%h valid=%b ret=%b mis=%b want all 0",
                      rx_data, rx_valid, ret_out_L, rx_misroute);
    end
    rst = 1'b0;
  endtask

  task automatic test_single_flit();
    tx_wr = 1'b1; tx_dest_x = 2'd0; tx_dest_y = 2'd0; tx_payload = 4'h5;
    @(negedge clk);
    tx_wr = 1'b0;
    total++;
    if (val_out_L !== 1'b0) begin
      bad++; $display("FAIL single_early: val_out got %b want 0", val_out_L);
    end
    @(negedge clk);
    total++;
    if (val_out_L !== 1'b1 || Data_out_L !== 8'h05) begin
      bad++; $display("FAIL single_present: got val=%b data=%h want val=1 data=05", val_out_L, Data_out_L);
    end
    ret_in_L = 1'b1;
    @(negedge clk);
    ret_in_L = 1'b0;
    total++;
    if (val_out_L !== 1'b0) begin
      bad++; $display("FAIL single_ret: val_out got %b want 0", val_out_L);
    end
    @(negedge clk);
    total++;
    if (val_out_L !== 1'b0 || tx_full !== 1'b0) begin
      bad++; $display("FAIL single_idle: got val=%b full=%b want 0 0", val_out_L, tx_full);
    end
  endtask

  task automatic test_fifo_full();
    logic [7:0] exp [4];
    int         w;
    logic       seen;
    ret_in_L = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tx_wr = 1'b1; tx_dest_x = 2'(i); tx_dest_y = 2'(3 - i); tx_payload = 4'(i + 1);
      if (i < 4) exp[i] = {2'(i), 2'(3 - i), 4'(i + 1)};
      @(negedge clk);
      total++;
      if (tx_full !== (i >= 3)) begin
        bad++; $display("FAIL fifo_full_w%0d: tx_full got %b want %b", i, tx_full, (i >= 3));
      end
    end
    tx_wr = 1'b0;
    for (int k = 0; k < 4; k++) begin
      w = 0;
      while (val_out_L !== 1'b1 && w < 6) begin
        @(negedge clk); w++;
      end
      total++;
      if (val_out_L !== 1'b1 || Data_out_L !== exp[k]) begin
        bad++; $display("FAIL fifo_order_%0d: got val=%b data=%h want val=1 data=%h", k, val_out_L, Data_out_L, exp[k]);
      end
      ret_in_L = 1'b1;
      @(negedge clk);
      ret_in_L = 1'b0;
      total++;
      if (val_out_L !== 1'b0) begin
        bad++; $display("FAIL fifo_gap_%0d: val_out got %b want 0", k, val_out_L);
      end
    end
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (val_out_L === 1'b1) seen = 1'b1;
    end
    total++;
    if (seen !== 1'b0 || tx_full !== 1'b0) begin
      bad++; $display("FAIL fifo_fifth_dropped: got extra_send=%b full=%b want 0 0", seen, tx_full);
    end
  endtask

  task automatic test_rx_capture();
    X_address = 2'd1; Y_address = 2'd1;
    rx_rd = 1'b0; Data_in_L = 8'h5A; val_in_L = 1'b1;
    @(negedge clk);
    total++;
    if ({ret_out_L, rx_valid, rx_data, rx_misroute} !== {1'b1, 1'b1, 4'hA, 1'b0}) begin
      bad++; $display("FAIL rx_capture: got ret=%b valid=%b data=%h mis=%b want 1 1 a 0",
                      ret_out_L, rx_valid, rx_data, rx_misroute);
    end
    @(negedge clk);
    total++;
    if (ret_out_L !== 1'b0 || rx_data !== 4'hA || rx_valid !== 1'b1) begin
      bad++; $display("FAIL rx_one_pulse: got ret=%b data=%h valid=%b want 0 a 1", ret_out_L, rx_data, rx_valid);
    end
    val_in_L = 1'b0;
  endtask

  task automatic test_rx_backpressure();
    Data_in_L = 8'h03; val_in_L = 1'b1; rx_rd = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      total++;
      if (ret_out_L !== 1'b0 || rx_data !== 4'hA) begin
        bad++; $display("FAIL rx_hold_%0d: got ret=%b data=%h want 0 a", c, ret_out_L, rx_data);
      end
    end
    rx_rd = 1'b1;
    @(negedge clk);
    rx_rd = 1'b0; val_in_L = 1'b0;
    total++;
    if ({ret_out_L, rx_misroute, rx_data, rx_valid} !== {1'b1, 1'b1, 4'h3, 1'b1}) begin
      bad++; $display("FAIL rx_misroute: got ret=%b mis=%b data=%h valid=%b want 1 1 3 1",
                      ret_out_L, rx_misroute, rx_data, rx_valid);
    end
    @(negedge clk);
    total++;
    if (ret_out_L !== 1'b0 || rx_misroute !== 1'b0) begin
      bad++; $display("FAIL rx_pulse_end: got ret=%b mis=%b want 0 0", ret_out_L, rx_misroute);
    end
    rx_rd = 1'b1;
    @(negedge clk);
    total++;
    if (rx_valid !== 1'b0) begin
      bad++; $display("FAIL rx_read_clear: rx_valid got %b want 0", rx_valid);
    end
    @(negedge clk);
    rx_rd = 1'b0;
    total++;
    if (rx_valid !== 1'b0 || ret_out_L !== 1'b0) begin
      bad++; $display("FAIL rx_read_empty: got valid=%b ret=%b want 0 0", rx_valid, ret_out_L);
    end
  endtask

  task automatic test_timeout();
    int   n;
    int   w;
    logic ok;
`ifdef NI_TIMEOUT_EN
    ret_in_L = 1'b0;
    tx_wr = 1'b1; tx_dest_x = 2'd2; tx_dest_y = 2'd1; tx_payload = 4'h7;
    @(negedge clk);
    tx_dest_x = 2'd1; tx_dest_y = 2'd2; tx_payload = 4'h8;
    @(negedge clk);
    tx_wr = 1'b0;
    n = 0; w = 0;
    while (timeout_err !== 1'b1 && w < 40) begin
      if (val_out_L === 1'b1 && Data_out_L === 8'h97) n++;
      @(negedge clk); w++;
    end
    total++;
    if (timeout_err !== 1'b1 || n != 15 || val_out_L !== 1'b0) begin
      bad++; $display("FAIL timeout_fire: got to=%b send_cycles=%0d val=%b want 1 15 0", timeout_err, n, val_out_L);
    end
    @(negedge clk);
    total++;
    if (timeout_err !== 1'b0 || val_out_L !== 1'b1 || Data_out_L !== 8'h68) begin
      bad++; $display("FAIL timeout_next: got to=%b val=%b data=%h want 0 1 68", timeout_err, val_out_L, Data_out_L);
    end
    ret_in_L = 1'b1;
    @(negedge clk);
    ret_in_L = 1'b0;
`else
    ret_in_L = 1'b0;
    tx_wr = 1'b1; tx_dest_x = 2'd2; tx_dest_y = 2'd1; tx_payload = 4'h7;
    @(negedge clk);
    tx_wr = 1'b0;
    @(negedge clk);
    ok = 1'b1; n = 0; w = 0;
    repeat (30) begin
      if (timeout_err !== 1'b0) ok = 1'b0;
      if (val_out_L !== 1'b1 || Data_out_L !== 8'h97) n++;
      @(negedge clk); w++;
    end
    total++;
    if (ok !== 1'b1 || n != 0) begin
      bad++; $display("FAIL timeout_none: got to_seen=%b drop_cycles=%0d over %0d want 0 0", !ok, n, w);
    end
    ret_in_L = 1'b1;
    @(negedge clk);
    ret_in_L = 1'b0;
`endif
  endtask

  task automatic test_random();
    int   old;
    logic push, cap;
    rst = 1'b1;
    idle_inputs();
    @(negedge clk);
    rst = 1'b0;
    mq.delete();
    m_data = 8'h00; m_val = 1'b0; m_to = 1'b0; m_wait = 0;
    m_rxd = 4'h0; m_rxv = 1'b0; m_ret = 1'b0; m_mis = 1'b0;
    X_address = 2'($urandom_range(0, 3));
    Y_address = 2'($urandom_range(0, 3));
    for (int c = 0; c < 600; c++) begin
      total++;
      if ({Data_out_L, val_out_L, tx_full, timeout_err} !== {m_data, m_val, (mq.size() == 4), m_to}) begin
        bad++; $display("FAIL rand_tx_c%0d: got data=%h val=%b full=%b to=%b want data=%h val=%b full=%b to=%b",
                        c, Data_out_L, val_out_L, tx_full, timeout_err, m_data, m_val, (mq.size() == 4), m_to);
      end
      total++;
      if ({rx_data, rx_valid, ret_out_L, rx_misroute} !== {m_rxd, m_rxv, m_ret, m_mis}) begin
        bad++; $display("FAIL rand_rx_c%0d: got data=%h valid=%b ret=%b mis=%b want data=%h valid=%b ret=%b mis=%b",
                        c, rx_data, rx_valid, ret_out_L, rx_misroute, m_rxd, m_rxv, m_ret, m_mis);
      end
      tx_wr      = 1'($urandom_range(0, 1));
      tx_dest_x  = 2'($urandom_range(0, 3));
      tx_dest_y  = 2'($urandom_range(0, 3));
      tx_payload = 4'($urandom_range(0, 15));
      ret_in_L   = ($urandom_range(0, 2) == 0);
      val_in_L   = 1'($urandom_range(0, 1));
      Data_in_L  = 8'($urandom_range(0, 255));
      rx_rd      = ($urandom_range(0, 2) == 0);
      // Model: what the next rising edge must do
      old  = mq.size();
      push = tx_wr && (old < 4);
      m_to = 1'b0;
      if (!m_val) begin
        if (old > 0) begin
          m_val = 1'b1; m_data = mq[0]; m_wait = 0;
        end
      end else if (ret_in_L) begin
        m_val = 1'b0; void'(mq.pop_front());
      end
`ifdef NI_TIMEOUT_EN
      else begin
        m_wait++;
        if (m_wait == 15) begin
          m_val = 1'b0; m_to = 1'b1; void'(mq.pop_front());
        end
      end
`endif
      if (push) mq.push_back({tx_dest_x, tx_dest_y, tx_payload});
      cap = val_in_L && !m_ret && (!m_rxv || rx_rd);
      if (cap) begin
        m_rxd = Data_in_L[3:0]; m_rxv = 1'b1; m_ret = 1'b1;
        m_mis = (Data_in_L[7:4] != {X_address, Y_address});
      end else begin
        m_ret = 1'b0; m_mis = 1'b0;
        if (rx_rd) m_rxv = 1'b0;
      end
      @(negedge clk);
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid_send();
    int   w;
    logic seen;
    rst = 1'b1;
    idle_inputs();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tx_wr = 1'b1; tx_dest_x = 2'(i); tx_dest_y = 2'(i); tx_payload = 4'(9 + i);
      @(negedge clk);
    end
    tx_wr = 1'b0;
    w = 0;
    while (val_out_L !== 1'b1 && w < 5) begin
      @(negedge clk); w++;
    end
    total++;
    if (val_out_L !== 1'b1) begin
      bad++; $display("FAIL midrst_send: val_out got %b want 1", val_out_L);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++;
    if ({val_out_L, tx_full, Data_out_L} !== 10'd0) begin
      bad++; $display("FAIL midrst_clear: got val=%b full=%b data=%h want 0 0 00", val_out_L, tx_full, Data_out_L);
    end
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (val_out_L !== 1'b0) seen = 1'b1;
    end
    total++;
    if (seen !== 1'b0) begin
      bad++; $display("FAIL midrst_nosend: flit after reset got %b want 0", seen);
    end
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    X_address = 2'd0; Y_address = 2'd0;
    tx_dest_x = 2'd0; tx_dest_y = 2'd0; tx_payload = 4'd0; Data_in_L = 8'h00;
    test_reset();
    test_single_flit();
    test_fifo_full();
    test_rx_capture();
    test_rx_backpressure();
    test_timeout();
    test_random();
    test_reset_mid_send();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
`default_nettype wire
